// File: rtl/rr_index_arbiter_pkg.sv
// rr_index_arbiter_pkg: shared widths and FSM encoding for the round-robin index arbiter
package rr_index_arbiter_pkg;
  localparam int N_CH = 32;
  localparam int IDX_W = 5;
  localparam int CNT_W = 8;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_e;
endpackage

// File: rtl/rr_index_arbiter_if.sv
// rr_index_arbiter_if: request/grant bundle between requesters and the arbiter
interface rr_index_arbiter_if;
  import rr_index_arbiter_pkg::*;
  logic [N_CH-1:0] req;
  logic rel;
  logic [IDX_W-1:0] gnt_idx;
  logic gnt_en;
  logic timeout;
  modport master (output req, rel, input gnt_idx, gnt_en, timeout);
  modport slave (input req, rel, output gnt_idx, gnt_en, timeout);
endinterface

// File: rtl/rr_index_arbiter_find_first.sv
// rr_find_first: first set bit of req searched circularly upward from ptr
module rr_find_first
  import rr_index_arbiter_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             found
);
  always_comb begin
    idx = '0;
    found = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[ptr + IDX_W'(i)]) begin
        idx = ptr + IDX_W'(i);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter: round-robin arbiter producing a registered grant index with hold timeout
module rr_index_arbiter
  import rr_index_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 255
) (
  input logic clk,
  input logic rst_n,
  rr_index_arbiter_if.slave b
);
  state_e state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx, idx_nx, win;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic found, en_nx, to_nx, lim, drop, fin;

  rr_find_first u_find (.req(b.req), .ptr(ptr), .idx(win), .found(found));

  // cnt counts cycles already held before this one, so the limit hits on the MAX_HOLD-th cycle
  assign lim = (MAX_HOLD != 0) && (int'(cnt) >= MAX_HOLD - 1);
  assign drop = !b.req[b.gnt_idx];
  assign fin = b.rel || drop || lim;

  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    cnt_nx = cnt;
    idx_nx = b.gnt_idx;
    en_nx = b.gnt_en;
    to_nx = 1'b0;
    if (state == IDLE) begin
      if (found) begin
        state_nx = GRANT;
        idx_nx = win;
        en_nx = 1'b1;
        cnt_nx = '0;
      end
    end else if (fin) begin
      state_nx = IDLE;
      en_nx = 1'b0;
      ptr_nx = b.gnt_idx + IDX_W'(1);
      to_nx = lim && !b.rel && !drop;
    end else begin
      cnt_nx = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= '0;
      cnt <= '0;
      b.gnt_idx <= '0;
      b.gnt_en <= 1'b0;
      b.timeout <= 1'b0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      cnt <= cnt_nx;
      b.gnt_idx <= idx_nx;
      b.gnt_en <= en_nx;
      b.timeout <= to_nx;
    end
  end
endmodule
